// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - shared widths, limits and state type for the 16-to-4 encoder
// Purpose: single home for the encoder data widths, error counter limit and
//          result buffer state encoding.
// Ports:   none (package).
package encoder_pkg;

    localparam int IN_W      = 16;
    localparam int CODE_W    = 4;
    localparam int ERR_CNT_W = 8;

    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

    // EMPTY: no unconsumed result; FULL: result register holds a result.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/prio_enc16.sv
// rtl/prio_enc16.sv - combinational highest-index priority encoder with multi-hit flag
// Purpose: encode a 16-bit request vector into the index of its highest set bit.
// Ports:   data_i  [15:0] request vector
//          code_o  [3:0]  index of highest set bit (0 when no bit set)
//          any_o          at least one bit set
//          multi_o        two or more bits set
module prio_enc16
    import encoder_pkg::*;
(
    input  logic [IN_W-1:0]   data_i,
    output logic [CODE_W-1:0] code_o,
    output logic              any_o,
    output logic              multi_o
);

    // Ascending scan: the last set bit seen wins, giving highest-index priority.
    always_comb begin
        code_o = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (data_i[i]) begin
                code_o = CODE_W'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    always_comb begin
        any_o   = |data_i;
        multi_o = |(data_i & (data_i - IN_W'(1)));
    end

endmodule

// File: rtl/encoder_16to4.sv
// rtl/encoder_16to4.sv - registered 16-to-4 priority encoder with one-entry ready/valid buffer
// Purpose: capture a request word on each accepted transfer, present its encoded
//          result one clock later, and count multi-hit words (saturating).
// Ports:   clk, rst_n           clock, asynchronous active-low reset
//          en_in, data_in       input word offer and payload
//          in_ready             word can be accepted this cycle
//          out_valid, out_ready result handshake
//          code_out, any_out,   encoded result of the captured word
//          multi_err
//          err_cnt              saturating count of accepted multi-hit words
module encoder_16to4
    import encoder_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_in,
    input  logic [IN_W-1:0]      data_in,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CODE_W-1:0]    code_out,
    output logic                 any_out,
    output logic                 multi_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    state_e                 state_q, state_d;
    logic [CODE_W-1:0]      code_q;
    logic                   any_q;
    logic                   multi_q;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic [CODE_W-1:0]      enc_code;
    logic                   enc_any;
    logic                   enc_multi;
    logic                   transfer;

    prio_enc16 u_prio_enc16 (
        .data_i  (data_in),
        .code_o  (enc_code),
        .any_o   (enc_any),
        .multi_o (enc_multi)
    );

    assign transfer = en_in && in_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a transfer while FULL is only possible when the
    // consumer drains in the same cycle, so the buffer stays FULL.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (transfer)                state_d = FULL;
            FULL:    if (out_ready && !transfer)  state_d = EMPTY;
            default:                              state_d = EMPTY;
        endcase
    end

    // Handshake outputs
    always_comb begin
        out_valid = (state_q == FULL);
        in_ready  = (state_q != FULL) || out_ready;
    end

    // Result registers only move on a transfer; draining leaves them as-is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q  <= '0;
            any_q   <= 1'b0;
            multi_q <= 1'b0;
        end else if (transfer) begin
            code_q  <= enc_code;
            any_q   <= enc_any;
            multi_q <= enc_multi;
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (transfer && enc_multi && (err_cnt_q != ERR_CNT_MAX)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign code_out  = code_q;
    assign any_out   = any_q;
    assign multi_err = multi_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_encoder_16to4.sv
// tb/tb_encoder_16to4.sv - self-checking bench for encoder_16to4
module tb_encoder_16to4;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  exp_code;
        logic        exp_any;
        logic        exp_multi;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        en_in;
    logic [15:0] data_in;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  code_out;
    logic        any_out;
    logic        multi_err;
    logic [7:0]  err_cnt;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_err = 0;
    vec_t vecs[$];

    encoder_16to4 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_in     (en_in),
        .data_in   (data_in),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .code_out  (code_out),
        .any_out   (any_out),
        .multi_err (multi_err),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Offer one word at a negedge, let the next posedge take it, sample 1 after.
    task automatic xfer(input logic [15:0] d);
        @(negedge clk);
        en_in   = 1'b1;
        data_in = d;
        @(posedge clk);
        #1;
        en_in   = 1'b0;
    endtask

    task automatic bump_err();
        exp_err = (exp_err >= 255) ? 255 : exp_err + 1;
    endtask

    initial begin
        vec_t v;
        for (int k = 0; k < 16; k++) begin
            v.data = 16'(1) << k; v.exp_code = 4'(k); v.exp_any = 1'b1; v.exp_multi = 1'b0;
            vecs.push_back(v);
        end
        v.data = 16'h0A50; v.exp_code = 4'd11; v.exp_any = 1'b1; v.exp_multi = 1'b1; vecs.push_back(v);
        v.data = 16'h0000; v.exp_code = 4'd0;  v.exp_any = 1'b0; v.exp_multi = 1'b0; vecs.push_back(v);
        v.data = 16'h8001; v.exp_code = 4'd15; v.exp_any = 1'b1; v.exp_multi = 1'b1; vecs.push_back(v);
        v.data = 16'h0003; v.exp_code = 4'd1;  v.exp_any = 1'b1; v.exp_multi = 1'b1; vecs.push_back(v);
        v.data = 16'hFFFF; v.exp_code = 4'd15; v.exp_any = 1'b1; v.exp_multi = 1'b1; vecs.push_back(v);
        v.data = 16'h0040; v.exp_code = 4'd6;  v.exp_any = 1'b1; v.exp_multi = 1'b0; vecs.push_back(v);

        // Reset state
        rst_n = 1'b0; en_in = 1'b0; data_in = 16'h0; out_ready = 1'b1;
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_code",      code_out,  0);
        chk("rst_any",       any_out,   0);
        chk("rst_multi",     multi_err, 0);
        chk("rst_err_cnt",   err_cnt,   0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Table: first entry lands on the first posedge after release
        foreach (vecs[i]) begin
            xfer(vecs[i].data);
            if (vecs[i].exp_multi) bump_err();
            chk($sformatf("vec%0d_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_code", i),  code_out,  vecs[i].exp_code);
            chk($sformatf("vec%0d_any", i),   any_out,   vecs[i].exp_any);
            chk($sformatf("vec%0d_multi", i), multi_err, vecs[i].exp_multi);
            chk($sformatf("vec%0d_err", i),   err_cnt,   exp_err);
        end

        // Drain, then backpressure
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("drain_valid", out_valid, 0);
        out_ready = 1'b0;
        xfer(16'h0010);
        chk("bp_first_code", code_out, 4);
        en_in = 1'b1; data_in = 16'h0100;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_code",  code_out,  4);
            chk("bp_in_ready",   in_ready,  0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1 chk("bp_ready_comb", in_ready, 1);
        @(posedge clk); #1;
        en_in = 1'b0;
        chk("bp_next_valid", out_valid, 1);
        chk("bp_next_code",  code_out,  8);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            chk("underflow_valid", out_valid, 0);
            chk("underflow_code",  code_out,  8);
            chk("underflow_err",   err_cnt,   exp_err);
        end

        // Simultaneous drain and capture
        out_ready = 1'b0;
        xfer(16'h0004);
        chk("sim_first_code", code_out, 2);
        @(negedge clk);
        en_in = 1'b1; data_in = 16'h2000; out_ready = 1'b1;
        @(posedge clk); #1;
        en_in = 1'b0;
        chk("sim_valid", out_valid, 1);
        chk("sim_code",  code_out,  13);

        // Saturation of the error counter, checked after every transfer
        out_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            xfer(16'hFFFF);
            bump_err();
            chk("sat_err", err_cnt, exp_err);
        end
        chk("sat_final", err_cnt, 255);

        // Asynchronous reset while FULL with err_cnt = 7
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_err = 0;
        for (int n = 0; n < 7; n++) begin
            xfer(16'h0003);
            bump_err();
        end
        out_ready = 1'b0;
        chk("ar_pre_valid", out_valid, 1);
        chk("ar_pre_err",   err_cnt,   7);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid",    out_valid, 0);
        chk("ar_err",      err_cnt,   0);
        chk("ar_code",     code_out,  0);
        chk("ar_in_ready", in_ready,  1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("ar_post_in_ready", in_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/encoder_16to4.md
ENCODER_16TO4 -- requirements
Module: encoder_16to4

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port: en_in  input  1  input valid; word on data_in offered this cycle.
REQ-004 SHALL have port: data_in  input  16  request vector to encode.
REQ-005 SHALL have port: in_ready  output  1  block can accept a word this cycle.
REQ-006 SHALL have port: out_valid  output  1  result register holds an unconsumed result.
REQ-007 SHALL have port: out_ready  input  1  consumer accepts the result this cycle.
REQ-008 SHALL have port: code_out  output  4  index of highest set bit of the captured word.
REQ-009 SHALL have port: any_out  output  1  captured word had at least one bit set.
REQ-010 SHALL have port: multi_err  output  1  captured word had two or more bits set.
REQ-011 SHALL have port: err_cnt  output  8  count of accepted words with multi_err, saturating.

Function
REQ-012 SHALL accept a word (transfer) in a cycle where en_in=1 and in_ready=1.
REQ-013 SHALL drive in_ready = !out_valid || out_ready (combinational; one-entry buffer, full throughput).
REQ-014 SHALL implement two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 SHALL transition EMPTY->FULL on a transfer; FULL->EMPTY on out_ready=1 with no transfer; FULL->FULL on a simultaneous out_ready=1 and transfer (new result replaces old in the same edge).
REQ-016 SHALL present the result one clock after the transfer edge (latency 1) and hold code_out, any_out, multi_err stable while FULL and out_ready=0.
REQ-017 SHALL encode with highest index priority: data_in=16'h8001 -> code_out=15.
REQ-018 SHALL, for data_in=16'h0000, set code_out=0, any_out=0, multi_err=0.
REQ-019 SHALL set multi_err=1 iff popcount(data_in) >= 2 at transfer.
REQ-020 SHALL increment err_cnt by 1 on each transfer with popcount >= 2, hold at 255 (no wrap).
REQ-021 SHALL ignore data_in and leave all state unchanged when en_in=0 or in_ready=0.
REQ-022 SHALL not change output registers when out_valid=0 and out_ready=1 with no transfer (no underflow effect).

Reset
REQ-023 SHALL on rst_n=0 immediately force state EMPTY, out_valid=0, code_out=0, any_out=0, multi_err=0, err_cnt=0, regardless of clk.
REQ-024 SHALL discard any held result on reset mid-operation; in_ready=1 while in reset and after release.
REQ-025 SHALL perform the first transfer on the first rising edge after rst_n deasserts with en_in=1.

Structure
REQ-026 SHALL place IN_W=16, CODE_W=4, ERR_CNT_W=8, ERR_CNT_MAX=255 and the state enum (EMPTY, FULL) in package encoder_pkg.
REQ-027 SHALL contain one combinational sub-module prio_enc16 (data 16 -> code 4, any, multi); all registers and handshake in encoder_16to4.

Verification
REQ-028 Walking one: after reset, data_in=1<<k for k=0..15, out_ready=1 -> code_out=k, any_out=1, multi_err=0 one cycle after each transfer, err_cnt=0.
REQ-029 Priority/zero: data_in=16'h0A50 -> code_out=11, multi_err=1, err_cnt=1; data_in=16'h0000 -> code_out=0, any_out=0.
REQ-030 Backpressure: transfer 16'h0010 with out_ready=0 for 5 cycles -> out_valid=1, code_out=4 held, in_ready=0; offered 16'h0100 not captured until out_ready=1.
REQ-031 Simultaneous: FULL with 16'h0004, out_ready=1 and en_in=1 data 16'h2000 same cycle -> next cycle out_valid=1, code_out=13.
REQ-032 Saturation: 300 transfers of 16'hFFFF -> err_cnt=255, stays 255.
REQ-033 Async reset mid-operation: FULL, err_cnt=7, rst_n low between edges -> out_valid=0, err_cnt=0 before next edge, in_ready=1.
